branch_compare_unit: RTL and testbench

Compares two 32-bit operands for RISC-V conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) and produces a taken/not-taken decision plus the raw relation flags. The primary outputs are combinational with zero latency, for same-cycle branch resolution in the execute stage. A registered copy of the flags is also provided for pipelined consumers. The block sits beside the ALU and feeds the PC-select logic.

---
 rtl/branch_compare_unit_pkg.sv | 16 +
 rtl/branch_magnitude_cmp.sv | 24 ++
 rtl/branch_compare_unit.sv | 64 ++++++
 tb/tb_branch_compare_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/branch_compare_unit_pkg.sv
// Shared definitions for the branch comparator: operand width and the
// funct3-encoded branch types.
package branch_compare_unit_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_ctrl_e;

endpackage

// File: rtl/branch_magnitude_cmp.sv
// Equality and less-than on XLEN-bit operands using one XLEN+1-bit
// subtraction; the extension bit selects signed or unsigned ordering.
module branch_magnitude_cmp #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            is_unsigned,
  output logic            eq,
  output logic            lt
);

  logic [XLEN:0] w_ext_a;
  logic [XLEN:0] w_ext_b;

  // Sign-extend for signed compares, zero-extend for unsigned; the extra bit
  // makes the difference's MSB the true sign for both interpretations.
  assign w_ext_a = {(~is_unsigned) & a[XLEN-1], a};
  assign w_ext_b = {(~is_unsigned) & b[XLEN-1], b};

  assign lt = 1'((w_ext_a - w_ext_b) >> XLEN);
  assign eq = ((a ^ b) == '0);

endmodule

// File: rtl/branch_compare_unit.sv
// RISC-V branch comparator: zero-latency relation flags and taken decision,
// plus a registered copy for pipelined consumers.
module branch_compare_unit
  import branch_compare_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      Br_Ctrl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            EQ,
  output logic            NE,
  output logic            LT,
  output logic            GE,
  output logic            BrOut,
  output logic            EQ_q,
  output logic            NE_q,
  output logic            LT_q,
  output logic            GE_q,
  output logic            BrOut_q
);

  logic       w_eq;
  logic       w_lt;
  logic       w_br;
  logic [4:0] r_flags;

  branch_magnitude_cmp #(
    .XLEN(XLEN)
  ) u_cmp (
    .a          (SrcA),
    .b          (SrcB),
    .is_unsigned(Br_Ctrl[1]),
    .eq         (w_eq),
    .lt         (w_lt)
  );

  always_comb begin
    w_br = 1'b0;
    case (Br_Ctrl)
      BR_EQ:         w_br = w_eq;
      BR_NE:         w_br = ~w_eq;
      BR_LT, BR_LTU: w_br = w_lt;
      BR_GE, BR_GEU: w_br = ~w_lt;
      default:       w_br = 1'b0;
    endcase
  end

  assign EQ    = w_eq;
  assign NE    = ~w_eq;
  assign LT    = w_lt;
  assign GE    = ~w_lt;
  assign BrOut = w_br;

  always_ff @(posedge clk) begin
    if (rst) r_flags <= '0;
    else     r_flags <= {w_eq, ~w_eq, w_lt, ~w_lt, w_br};
  end

  assign {EQ_q, NE_q, LT_q, GE_q, BrOut_q} = r_flags;

endmodule

// File: tb/tb_branch_compare_unit.sv
// Scoreboard bench for branch_compare_unit: stimulus pushes expected
// combinational and registered flags; monitors pop and compare.
module tb_branch_compare_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  Br_Ctrl = 3'b000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        EQ, NE, LT, GE, BrOut;
  logic        EQ_q, NE_q, LT_q, GE_q, BrOut_q;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  flags; // {eq, ne, lt, ge, br}
  } exp_t;

  exp_t q_comb[$];
  exp_t q_reg[$];
  int   errors = 0;
  int   checks = 0;

  branch_compare_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .Br_Ctrl(Br_Ctrl), .SrcA(SrcA), .SrcB(SrcB),
    .EQ(EQ), .NE(NE), .LT(LT), .GE(GE), .BrOut(BrOut),
    .EQ_q(EQ_q), .NE_q(NE_q), .LT_q(LT_q), .GE_q(GE_q), .BrOut_q(BrOut_q)
  );

  initial forever #5 clk = ~clk;

  // Reference built from language compare operators, not from subtraction.
  function automatic logic [4:0] ref_flags(input logic [2:0] c,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic eq, lt, br;
    eq = (a == b);
    lt = c[1] ? (a < b) : ($signed(a) < $signed(b));
    case (c)
      3'b000:         br = eq;
      3'b001:         br = !eq;
      3'b100, 3'b110: br = lt;
      3'b101, 3'b111: br = !lt;
      default:        br = 1'b0;
    endcase
    return {eq, !eq, lt, !lt, br};
  endfunction

  task automatic apply(input logic r, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] exp_f);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r; Br_Ctrl = c; SrcA = a; SrcB = b;
    e = '{ctrl: c, a: a, b: b, flags: exp_f};
    q_comb.push_back(e);
    if (r) e.flags = '0;
    q_reg.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q_comb.size() > 0) begin
      exp_t e;
      e = q_comb.pop_front();
      checks++;
      if ({EQ, NE, LT, GE, BrOut} !== e.flags) begin
        errors++;
        $display("FAIL comb ctrl=%b a=%h b=%h got=%b exp=%b",
                 e.ctrl, e.a, e.b, {EQ, NE, LT, GE, BrOut}, e.flags);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (q_reg.size() > 0) begin
      exp_t e;
      e = q_reg.pop_front();
      checks++;
      if ({EQ_q, NE_q, LT_q, GE_q, BrOut_q} !== e.flags) begin
        errors++;
        $display("FAIL reg ctrl=%b a=%h b=%h got=%b exp=%b",
                 e.ctrl, e.a, e.b, {EQ_q, NE_q, LT_q, GE_q, BrOut_q}, e.flags);
      end
    end
  end

  initial begin
    // Reset held with inputs giving BrOut=1: registered copy zero, comb live.
    apply(1'b1, 3'b000, 32'h12345678, 32'h12345678, 5'b10011);
    apply(1'b1, 3'b000, 32'h12345678, 32'h12345678, 5'b10011);
    apply(1'b0, 3'b000, 32'h12345678, 32'h12345678, 5'b10011);

    // Equal operands across all legal codes.
    apply(1'b0, 3'b001, 32'h12345678, 32'h12345678, 5'b10010);
    apply(1'b0, 3'b100, 32'h12345678, 32'h12345678, 5'b10010);
    apply(1'b0, 3'b101, 32'h12345678, 32'h12345678, 5'b10011);
    apply(1'b0, 3'b110, 32'h12345678, 32'h12345678, 5'b10010);
    apply(1'b0, 3'b111, 32'h12345678, 32'h12345678, 5'b10011);

    // Most-negative vs most-positive.
    apply(1'b0, 3'b000, 32'h80000000, 32'h7FFFFFFF, 5'b01100);
    apply(1'b0, 3'b001, 32'h80000000, 32'h7FFFFFFF, 5'b01101);
    apply(1'b0, 3'b100, 32'h80000000, 32'h7FFFFFFF, 5'b01101);
    apply(1'b0, 3'b101, 32'h80000000, 32'h7FFFFFFF, 5'b01100);
    apply(1'b0, 3'b110, 32'h80000000, 32'h7FFFFFFF, 5'b01010);
    apply(1'b0, 3'b111, 32'h80000000, 32'h7FFFFFFF, 5'b01011);

    // -1 vs 0 and -1 vs 1.
    apply(1'b0, 3'b100, 32'hFFFFFFFF, 32'h00000000, 5'b01101);
    apply(1'b0, 3'b110, 32'hFFFFFFFF, 32'h00000000, 5'b01010);
    apply(1'b0, 3'b101, 32'hFFFFFFFF, 32'h00000001, 5'b01100);
    apply(1'b0, 3'b111, 32'hFFFFFFFF, 32'h00000001, 5'b01011);

    // Reserved codes: no branch, flags unsigned.
    apply(1'b0, 3'b010, 32'h00000001, 32'h00000002, 5'b01100);
    apply(1'b0, 3'b011, 32'h00000001, 32'h00000002, 5'b01100);
    apply(1'b0, 3'b010, 32'hFFFFFFFF, 32'h00000001, 5'b01010);

    // Reset mid-run, then release.
    apply(1'b0, 3'b111, 32'h00000005, 32'h00000005, 5'b10011);
    apply(1'b1, 3'b111, 32'h00000005, 32'h00000005, 5'b10011);
    apply(1'b0, 3'b111, 32'h00000005, 32'h00000005, 5'b10011);

    // Randomised sweep over legal codes against the operator reference.
    for (int i = 0; i < 300; i++) begin
      logic [2:0]  c;
      logic [31:0] a, b;
      case (i % 6)
        0: c = 3'b000; 1: c = 3'b001; 2: c = 3'b100;
        3: c = 3'b101; 4: c = 3'b110; default: c = 3'b111;
      endcase
      a = $urandom;
      b = (i % 7 == 0) ? a : $urandom;
      apply(1'b0, c, a, b, ref_flags(c, a, b));
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q_comb.size() != 0 || q_reg.size() != 0) begin
      errors++;
      $display("FAIL drain comb_left=%0d reg_left=%0d required=0",
               q_comb.size(), q_reg.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
